basic_and_sequencer: RTL and testbench

Synchronous controller that drives one toggle-encoded two-input AND cell (inputs `a`, `b`, `clk`; output `out`, each edge one event). It queues operand requests, issues the cell's `a`, `b` and `clk` events in fixed order with a programmable gap so every hold window is met, watches `out` for a response window, and returns the result and an error flag. It sits between the test/system logic and the cell under characterisation.

---
 rtl/basic_and_sequencer.sv | 169 ++++++++++++++++
 tb/tb_basic_and_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_and_sequencer.sv
// Sequencer for a toggle-encoded two-input AND cell: queues operand requests,
// issues a/b/clk events with a programmable gap, then counts out-edges in a window.
module basic_and_sequencer #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4,
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_a,
  input  logic             req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_out,
  output logic             rsp_err,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_clk,
  input  logic             cell_out,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (GAP_W > WIN_W) ? GAP_W : WIN_W;

  typedef enum logic [2:0] {
    IDLE, DRV_A, GAP_A, DRV_B, GAP_B, DRV_CLK, WAIT, RESP
  } state_t;

  state_t        state_q;
  logic [1:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          ready_en_q;
  logic          empty, full, push, pop;
  logic [1:0]    head;
  logic [CW-1:0] gap_eff_d, win_eff_d;
  logic [CW-1:0] gap_q, win_q, cnt_q;
  logic          op_a_q, op_b_q;
  logic          cell_out_q, edge_d;
  logic [1:0]    count_q, count_d;
  logic          stray_q;
  logic          rsp_valid_q, rsp_out_q, rsp_err_q;
  logic          cell_a_q, cell_b_q, cell_clk_q;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign req_ready = ready_en_q && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign gap_eff_d = (cfg_gap == '0) ? CW'(1) : CW'(cfg_gap);
  assign win_eff_d = (CW'(cfg_win) < gap_eff_d) ? gap_eff_d : CW'(cfg_win);

  assign edge_d  = cell_out ^ cell_out_q;
  assign count_d = (edge_d && (count_q != 2'b11)) ? count_q + 2'd1 : count_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_err   = rsp_err_q;
  assign cell_a    = cell_a_q;
  assign cell_b    = cell_b_q;
  assign cell_clk  = cell_clk_q;
  assign busy      = (state_q != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {req_a, req_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      op_a_q      <= 1'b0;
      op_b_q      <= 1'b0;
      cell_out_q  <= 1'b0;
      count_q     <= '0;
      stray_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      cell_a_q    <= 1'b0;
      cell_b_q    <= 1'b0;
      cell_clk_q  <= 1'b0;
    end else begin
      cell_out_q <= cell_out;
      if (edge_d && (state_q != WAIT)) stray_q <= 1'b1;
      case (state_q)
        IDLE: if (!empty) begin
          op_a_q  <= head[1];
          op_b_q  <= head[0];
          gap_q   <= gap_eff_d;
          win_q   <= win_eff_d;
          state_q <= head[1] ? DRV_A : (head[0] ? DRV_B : DRV_CLK);
        end
        DRV_A: begin
          cell_a_q <= ~cell_a_q;
          if (gap_q > CW'(1)) begin
            cnt_q   <= gap_q - CW'(2);
            state_q <= GAP_A;
          end else begin
            state_q <= op_b_q ? DRV_B : DRV_CLK;
          end
        end
        GAP_A: begin
          if (cnt_q == '0) state_q <= op_b_q ? DRV_B : DRV_CLK;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        DRV_B: begin
          cell_b_q <= ~cell_b_q;
          if (gap_q > CW'(1)) begin
            cnt_q   <= gap_q - CW'(2);
            state_q <= GAP_B;
          end else begin
            state_q <= DRV_CLK;
          end
        end
        GAP_B: begin
          if (cnt_q == '0) state_q <= DRV_CLK;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        DRV_CLK: begin
          cell_clk_q <= ~cell_clk_q;
          count_q    <= '0;
          cnt_q      <= win_q - CW'(1);
          state_q    <= WAIT;
        end
        WAIT: begin
          count_q <= count_d;
          if (cnt_q == '0) begin
            // Pending stray moves into the response here; later edges re-arm stray_q.
            rsp_valid_q <= 1'b1;
            rsp_out_q   <= count_d[0];
            rsp_err_q   <= (count_d != {1'b0, op_a_q & op_b_q}) || stray_q;
            stray_q     <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_basic_and_sequencer.sv
// Scoreboard bench for basic_and_sequencer with a behavioural toggle-encoded AND
// cell model; expectations come from event counting, checked by a negedge monitor.
module tb_basic_and_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cfg_gap, cfg_win;
  logic       req_valid, req_ready, req_a, req_b;
  logic       rsp_valid, rsp_out, rsp_err;
  logic       rsp_ready = 1'b0;
  logic       cell_a, cell_b, cell_clk;
  logic       cell_out = 1'b0;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
  int cell_mode  = 0;   // 0 correct AND, 1 never answers, 2 answers twice
  int cell_delay = 1;   // cycles from clk event to out toggle
  int inj_cnt    = 0;

  logic [1:0] exp_q[$]; // {rsp_out, rsp_err}

  basic_and_sequencer #(.DEPTH(4), .GAP_W(4), .WIN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_gap(cfg_gap), .cfg_win(cfg_win),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_err(rsp_err),
    .cell_a(cell_a), .cell_b(cell_b), .cell_clk(cell_clk), .cell_out(cell_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: number of out events the cell produces, then the response rules.
  function automatic logic [1:0] ref_rsp(input logic a, input logic b, input int mode,
                                         input bit stray);
    int n, cnt;
    if (mode == 0)      n = (a & b) ? 1 : 0;
    else if (mode == 1) n = 0;
    else                n = (a & b) ? 2 : 0;
    cnt = (n > 3) ? 3 : n;
    return {(n % 2) == 1, (cnt != int'(a & b)) || stray};
  endfunction

  // rsp_ready driver
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      rsp_ready = 1'b0;
    else if (ready_mode == 1) rsp_ready = 1'b1;
    else                      rsp_ready = 1'($urandom_range(0, 1));
  end

  // Cell model: remembers a/b events since the last clk event, answers after cell_delay.
  bit pa, pb, prev_a, prev_b, prev_c;
  int tog_left, wait_left, inj_done;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cell_out = 1'b0; pa = 0; pb = 0; prev_a = 0; prev_b = 0; prev_c = 0;
      tog_left = 0; wait_left = 0; inj_done = inj_cnt;
    end else begin
      if (cell_a != prev_a) pa = 1;
      if (cell_b != prev_b) pb = 1;
      if (cell_clk != prev_c) begin
        if (cell_mode == 0)      tog_left = (pa && pb) ? 1 : 0;
        else if (cell_mode == 1) tog_left = 0;
        else                     tog_left = (pa && pb) ? 2 : 0;
        wait_left = cell_delay - 1;
        pa = 0; pb = 0;
      end
      prev_a = cell_a; prev_b = cell_b; prev_c = cell_clk;
      if (tog_left > 0) begin
        if (wait_left == 0) begin
          cell_out = ~cell_out;
          tog_left--;
        end else begin
          wait_left--;
        end
      end
      if (inj_done != inj_cnt) begin
        cell_out = ~cell_out;
        inj_done++;
      end
    end
  end

  // Monitor: held responses must match the head; handshakes pop it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got out=%0d err=%0d expected no response (cycle %0d)",
                 rsp_out, rsp_err, cyc);
      end else if (rsp_ready) begin
        chk("rsp_out", rsp_out, exp_q[0][1]);
        chk("rsp_err", rsp_err, exp_q[0][0]);
        void'(exp_q.pop_front());
      end else begin
        chk("held_rsp", {rsp_out, rsp_err}, exp_q[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic a, input logic b, input bit stray, output int t);
    int n = 0;
    req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 300) begin step(); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
      t = -1;
    end else begin
      step();
      t = cyc;
      exp_q.push_back(ref_rsp(a, b, cell_mode, stray));
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 2000) begin step(); n++; end
    if (exp_q.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // First cycles at which each cell drive and rsp_valid change after acceptance at t.
  task automatic track(input string tag, input int ea, input int eb, input int ec,
                       input int ev);
    logic a0 = cell_a, b0 = cell_b, c0 = cell_clk;
    int ta = -1, tb = -1, tc = -1, tv = -1;
    for (int i = 0; i < 100 && tv < 0; i++) begin
      step();
      if (ta < 0 && cell_a != a0) ta = cyc;
      if (tb < 0 && cell_b != b0) tb = cyc;
      if (tc < 0 && cell_clk != c0) tc = cyc;
      if (tv < 0 && rsp_valid) tv = cyc;
    end
    chk({tag, "_cell_a_cyc"}, ta, ea);
    chk({tag, "_cell_b_cyc"}, tb, eb);
    chk({tag, "_cell_clk_cyc"}, tc, ec);
    chk({tag, "_rsp_valid_cyc"}, tv, ev);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_out"}, rsp_out, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_cells"}, {cell_a, cell_b, cell_clk}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int t, g, w;
    rst_n = 1'b0; req_valid = 1'b0; req_a = 1'b0; req_b = 1'b0;
    cfg_gap = 4'd2; cfg_win = 4'd3;
    #3;
    chk_all_zero("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("ready_after_reset", req_ready, 1);

    // {1,1}, gap 2, window 3, cell answers 2 cycles after clk
    cell_delay = 2;
    push(1'b1, 1'b1, 1'b0, t);
    track("t11", t + 2, t + 4, t + 6, t + 9);
    drain();

    // skipped operands, gap 1, window 4
    cell_delay = 1; cfg_gap = 4'd1; cfg_win = 4'd4;
    push(1'b0, 1'b1, 1'b0, t);
    push(1'b1, 1'b0, 1'b0, t);
    drain();
    push(1'b0, 1'b0, 1'b0, t);
    track("t00", -1, -1, t + 2, t + 6);
    drain();

    // gap 0 acts as 1, window below gap is raised: {1,1} spans g=1,w=1
    cfg_gap = 4'd0; cfg_win = 4'd0;
    push(1'b1, 1'b1, 1'b0, t);
    track("g0", t + 2, t + 3, t + 4, t + 5);
    drain();
    cfg_gap = 4'd5; cfg_win = 4'd2;
    push(1'b1, 1'b0, 1'b0, t);
    track("wraise", t + 2, -1, t + 7, t + 12);
    drain();

    // backpressure: five requests with consumer stalled
    cfg_gap = 4'd1; cfg_win = 4'd2; ready_mode = 0;
    push(1'b1, 1'b1, 1'b0, t);
    push(1'b0, 1'b1, 1'b0, t);
    push(1'b1, 1'b1, 1'b0, t);
    push(1'b0, 1'b0, 1'b0, t);
    push(1'b1, 1'b0, 1'b0, t);
    chk("full_ready", req_ready, 0);
    repeat (8) step();
    chk("full_ready_held", req_ready, 0);
    chk("full_busy", busy, 1);
    ready_mode = 1;
    drain();

    // stray edge while idle taints only the next response
    cfg_win = 4'd4;
    inj_cnt++;
    repeat (3) step();
    push(1'b1, 1'b1, 1'b1, t);
    push(1'b1, 1'b1, 1'b0, t);
    drain();

    // faulty cell: silent, then double answer
    cell_mode = 1;
    push(1'b1, 1'b1, 1'b0, t);
    drain();
    cell_mode = 2;
    push(1'b1, 1'b1, 1'b0, t);
    drain();
    cell_mode = 0;

    // reset during GAP_B with two requests queued
    cfg_gap = 4'd4; cfg_win = 4'd4;
    push(1'b1, 1'b1, 1'b0, t);
    push(1'b0, 1'b1, 1'b0, t);
    push(1'b1, 1'b0, 1'b0, t);
    begin
      int n = 0;
      logic b0 = cell_b;
      while (cell_b == b0 && n < 100) begin step(); n++; end
      chk("reach_gap_b", cell_b != b0, 1);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    chk("postreset_busy", busy, 0);
    chk("postreset_ready", req_ready, 1);
    repeat (20) step();
    cfg_gap = 4'd1; cfg_win = 4'd2;
    push(1'b1, 1'b1, 1'b0, t);
    drain();

    // randomized traffic with random config and consumer stalls
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      cfg_gap = 4'($urandom_range(0, 15));
      cfg_win = 4'($urandom_range(0, 15));
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, t);
      repeat ($urandom_range(0, 3)) step();
    end
    ready_mode = 1;
    drain();
    chk("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
